// File: rtl/tft_pkg.sv
// Shared types and widths for the TFT write path: address field widths,
// default frame geometry and the pixel writer's phase encoding.
package tft_pkg;
  localparam int H_ACTIVE_DEF = 800;
  localparam int V_ACTIVE_DEF = 480;
  localparam int ROW_W  = 9;
  localparam int COL_W  = 10;
  localparam int PAGE_W = 3;
  localparam int PIX_W  = 16;

  typedef enum logic {CLEAR, RUN} state_e;
endpackage

// File: rtl/pix_fifo.sv
// Small synchronous pixel FIFO with flush. The head word is shown combinationally,
// so the consumer sees the next pixel in the cycle after a pop.
module pix_fifo
  import tft_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [PIX_W-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [PIX_W-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  // The pointers carry one extra wrap bit so that full and empty can be told apart.
  logic [AW:0]                  wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH-1:0][PIX_W-1:0] mem_q, mem_d;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    mem_d = mem_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push && !full) begin
        mem_d[wr_q[AW-1:0]] = din;
        wr_d = wr_q + (AW+1)'(1);
      end
      if (pop && !empty) rd_d = rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/tft_pixel_writer.sv
// Producer side of the TFT/SDRAM controller: clears the frame pages after reset,
// then streams host pixels through a FIFO while tracking the write address.
module tft_pixel_writer
  import tft_pkg::*;
#(
  parameter int             H_ACTIVE    = H_ACTIVE_DEF,
  parameter int             V_ACTIVE    = V_ACTIVE_DEF,
  parameter int             CLEAR_PAGES = 8,
  parameter logic [PIX_W-1:0] CLEAR_COLOR = 16'h0000,
  parameter int             DEPTH       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_frame_start,
  input  logic [PAGE_W-1:0] host_page,
  input  logic              host_pix_valid,
  input  logic [PIX_W-1:0]  host_pix_data,
  output logic              host_pix_ready,
  output logic              frame_done,
  input  logic              addr_inc,
  input  logic              fifo_rd_req,
  output logic              fifo_avail,
  output logic [PIX_W-1:0]  fifo_out,
  output logic              startup,
  output logic [PAGE_W-1:0] page_set,
  output logic [ROW_W-1:0]  row_add_user,
  output logic [COL_W-1:0]  col_add_user
);
  state_e            state_q, state_d;
  logic [PAGE_W-1:0] page_q, page_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              frame_done_q, frame_done_d;

  logic             in_run, push, pop, flush, full, empty;
  logic             col_end, row_end, page_end;
  logic [PIX_W-1:0] head;

  assign in_run = (state_q == RUN);
  // A frame start takes the whole cycle: any push or pop offered with it is dropped.
  assign flush  = in_run && host_frame_start;
  assign push   = in_run && !host_frame_start && host_pix_valid && !full;
  assign pop    = in_run && !host_frame_start && fifo_rd_req && !empty;

  pix_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (host_pix_data),
    .pop   (pop),
    .flush (flush),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign host_pix_ready = in_run && !full;
  assign fifo_avail     = in_run && !empty;
  assign fifo_out       = in_run ? head : CLEAR_COLOR;
  assign startup        = in_run;
  assign page_set       = page_q;
  assign row_add_user   = row_q;
  assign col_add_user   = col_q;
  assign frame_done     = frame_done_q;

  assign col_end  = (col_q  == COL_W'(H_ACTIVE - 1));
  assign row_end  = (row_q  == ROW_W'(V_ACTIVE - 1));
  assign page_end = (page_q == PAGE_W'(CLEAR_PAGES - 1));

  always_comb begin
    state_d      = state_q;
    page_d       = page_q;
    row_d        = row_q;
    col_d        = col_q;
    frame_done_d = 1'b0;
    case (state_q)
      CLEAR: begin
        if (addr_inc) begin
          if (!col_end) begin
            col_d = col_q + COL_W'(1);
          end else begin
            col_d = '0;
            if (!row_end) begin
              row_d = row_q + ROW_W'(1);
            end else begin
              row_d = '0;
              if (page_end) begin
                state_d = RUN;
                page_d  = '0;
              end else begin
                page_d = page_q + PAGE_W'(1);
              end
            end
          end
        end
      end
      RUN: begin
        if (flush) begin
          page_d = host_page;
          row_d  = '0;
          col_d  = '0;
        end else if (pop) begin
          // In RUN the page is owned by the host, so a row wrap only flags the frame end.
          if (!col_end) begin
            col_d = col_q + COL_W'(1);
          end else begin
            col_d = '0;
            if (!row_end) begin
              row_d = row_q + ROW_W'(1);
            end else begin
              row_d        = '0;
              frame_done_d = 1'b1;
            end
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEAR;
      page_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      page_q       <= page_d;
      row_q        <= row_d;
      col_q        <= col_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule

// File: tb/tb_tft_pixel_writer.sv
// Directed and randomized bench for tft_pixel_writer, checked against a
// queue-based reference model of the clear walk and the pixel stream.
module tb_tft_pixel_writer;
  localparam int          H   = 4;
  localparam int          V   = 3;
  localparam int          CP  = 2;
  localparam int          DEP = 4;
  localparam logic [15:0] CC  = 16'hA5C3;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_frame_start;
  logic [2:0]  host_page;
  logic        host_pix_valid;
  logic [15:0] host_pix_data;
  logic        host_pix_ready;
  logic        frame_done;
  logic        addr_inc;
  logic        fifo_rd_req;
  logic        fifo_avail;
  logic [15:0] fifo_out;
  logic        startup;
  logic [2:0]  page_set;
  logic [8:0]  row_add_user;
  logic [9:0]  col_add_user;

  tft_pixel_writer #(
    .H_ACTIVE(H), .V_ACTIVE(V), .CLEAR_PAGES(CP), .CLEAR_COLOR(CC), .DEPTH(DEP)
  ) dut (
    .clk(clk), .rst(rst),
    .host_frame_start(host_frame_start), .host_page(host_page),
    .host_pix_valid(host_pix_valid), .host_pix_data(host_pix_data),
    .host_pix_ready(host_pix_ready), .frame_done(frame_done),
    .addr_inc(addr_inc), .fifo_rd_req(fifo_rd_req),
    .fifo_avail(fifo_avail), .fifo_out(fifo_out), .startup(startup),
    .page_set(page_set), .row_add_user(row_add_user), .col_add_user(col_add_user)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: clear progress is a pulse count; in run the address is a
  // linear pixel index within the page, and the FIFO is a plain queue.
  bit          m_run;
  int          m_cnt;
  int          m_idx;
  logic [2:0]  m_page;
  logic [15:0] m_q[$];
  bit          m_fd;
  int          fd_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int pg, ix;
    if (m_run) begin
      pg = int'(m_page);
      ix = m_idx;
    end else begin
      pg = m_cnt / (V * H);
      ix = m_cnt % (V * H);
    end
    chk({tag, ".startup"}, 32'(startup), 32'(m_run));
    chk({tag, ".page"}, 32'(page_set), 32'(pg));
    chk({tag, ".row"}, 32'(row_add_user), 32'(ix / H));
    chk({tag, ".col"}, 32'(col_add_user), 32'(ix % H));
    chk({tag, ".avail"}, 32'(fifo_avail), 32'(m_run && m_q.size() > 0));
    chk({tag, ".ready"}, 32'(host_pix_ready), 32'(m_run && m_q.size() < DEP));
    chk({tag, ".fdone"}, 32'(frame_done), 32'(m_fd));
    if (!m_run) chk({tag, ".out_clr"}, 32'(fifo_out), 32'(CC));
    else if (m_q.size() > 0) chk({tag, ".out_head"}, 32'(fifo_out), 32'(m_q[0]));
  endtask

  task automatic cyc(input string tag, input bit r, input bit v, input logic [15:0] d,
                     input bit fs, input logic [2:0] hp, input bit ai, input bit rd);
    bit do_push, do_pop;
    rst = r; host_pix_valid = v; host_pix_data = d; host_frame_start = fs;
    host_page = hp; addr_inc = ai; fifo_rd_req = rd;
    @(posedge clk);
    m_fd = 1'b0;
    if (r) begin
      m_run = 0; m_cnt = 0; m_idx = 0; m_page = '0; m_q.delete();
    end else if (!m_run) begin
      if (ai) begin
        m_cnt++;
        if (m_cnt == CP * V * H) begin
          m_run = 1; m_page = '0; m_idx = 0;
        end
      end
    end else if (fs) begin
      m_q.delete(); m_page = hp; m_idx = 0;
    end else begin
      do_pop  = rd && (m_q.size() > 0);
      do_push = v && (m_q.size() < DEP);
      if (do_pop) begin
        void'(m_q.pop_front());
        m_idx++;
        if (m_idx == V * H) begin
          m_idx = 0;
          m_fd  = 1'b1;
        end
      end
      if (do_push) m_q.push_back(d);
    end
    #1;
    if (frame_done === 1'b1) fd_seen++;
    check_all(tag);
  endtask

  task automatic full_clear(input string tag);
    for (int i = 0; i < CP * V * H; i++)
      cyc(tag, 0, 1'($urandom), 16'($urandom), 1'($urandom), 3'($urandom), 1, 1'($urandom));
  endtask

  initial begin
    rst = 1; host_frame_start = 0; host_page = 0; host_pix_valid = 0;
    host_pix_data = 0; addr_inc = 0; fifo_rd_req = 0;
    m_run = 0; m_cnt = 0; m_idx = 0; m_page = 0; m_fd = 0; fd_seen = 0;

    cyc("reset", 1, 0, 0, 0, 0, 0, 0);
    cyc("reset2", 1, 1, 16'h1234, 1, 3, 1, 1);
    cyc("idle_clear", 0, 0, 0, 0, 0, 0, 0);

    // Clear walk with host noise that must be ignored.
    full_clear("clear");
    chk("startup_after_clear", 32'(startup), 32'(1));

    // Three pixels in, three out.
    cyc("push1", 0, 1, 16'h1111, 0, 0, 0, 0);
    cyc("push2", 0, 1, 16'h2222, 0, 0, 0, 0);
    cyc("push3", 0, 1, 16'h3333, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("pop3", 0, 0, 0, 0, 0, 0, 1);
    cyc("empty_rd", 0, 0, 0, 0, 0, 0, 1);

    // Fill past depth, then pop while the held pixel is still offered.
    for (int i = 0; i < DEP + 1; i++) cyc("fill", 0, 1, 16'(16'h4000 + i), 0, 0, 0, 0);
    cyc("full_pop_push", 0, 1, 16'h5555, 0, 0, 0, 1);
    cyc("refill", 0, 1, 16'h5555, 0, 0, 0, 0);
    for (int i = 0; i < DEP; i++) cyc("drain", 0, 0, 0, 0, 0, 0, 1);

    // One full page of pixels from a fresh frame start on page 3.
    cyc("fs3", 0, 0, 0, 1, 3'd3, 0, 0);
    fd_seen = 0;
    for (int i = 0; i < V * H; i++) cyc("stream", 0, 1, 16'($urandom), 0, 0, 0, i > 0);
    cyc("stream_last", 0, 0, 0, 0, 0, 0, 1);
    cyc("stream_tail", 0, 0, 0, 0, 0, 0, 1);
    chk("frame_done_count", 32'(fd_seen), 32'(1));

    // Frame start mid-frame with data queued and a concurrent push/pop.
    cyc("mid_push1", 0, 1, 16'hAAAA, 0, 0, 0, 1);
    cyc("mid_push2", 0, 1, 16'hBBBB, 0, 0, 0, 0);
    cyc("mid_push3", 0, 1, 16'hCCCC, 0, 0, 0, 0);
    cyc("fs5", 0, 1, 16'hDDDD, 1, 3'd5, 0, 1);
    chk("fs5_page", 32'(page_set), 32'(5));

    // Reset in RUN with data queued, then reset part-way through CLEAR.
    cyc("run_q1", 0, 1, 16'h7777, 0, 0, 0, 0);
    cyc("run_q2", 0, 1, 16'h8888, 0, 0, 0, 0);
    cyc("rst_run", 1, 1, 16'h9999, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) cyc("part_clear", 0, 0, 0, 0, 0, 1, 0);
    cyc("rst_clear", 1, 0, 0, 0, 0, 1, 0);
    full_clear("clear_again");

    // Randomized traffic including rare frame starts and resets.
    for (int i = 0; i < 600; i++)
      cyc("rand", ($urandom % 300) == 0, 1'($urandom), 16'($urandom),
          ($urandom % 40) == 0, 3'($urandom), 1'($urandom), ($urandom % 3) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
